softmax_unit: RTL
=================

Name: softmax_unit

Overview:
- Consumes the per-node attention scores that the score stage pushes into the softmax FIFO: one word per node holds signed scores plus a neighbour count.
- Normalises each word with a base-2, max-subtracted integer softmax and streams one alpha coefficient per neighbour to the aggregation stage.
- Sits directly downstream of the score FIFO and drives its read strobe.

Parameters:
- DATA_WIDTH, 8, width of each signed score.
- NUM_OF_NODES, 168, maximum neighbours per word.
- NUM_NODE_WIDTH, $clog2(NUM_OF_NODES), width of the count field.
- SOFTMAX_WIDTH, NUM_OF_NODES*DATA_WIDTH+NUM_NODE_WIDTH, FIFO word width.
- EXP_W, 16, width of the exponent term e_i.
- FRAC_W, 8, fractional bits of alpha.
- ALPHA_W, FRAC_W+1, alpha width, so the value 1.0 (2^FRAC_W) is representable.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- coef_data_i  in  SOFTMAX_WIDTH  FIFO head word (first-word-fall-through)
- coef_empty_i  in  1  FIFO empty
- coef_rd_valid_o  out  1  one-cycle pop strobe
- alpha_o  out  ALPHA_W  normalised coefficient, unsigned
- alpha_idx_o  out  NUM_NODE_WIDTH  neighbour index of alpha_o
- alpha_valid_o  out  1  alpha_o valid
- alpha_last_o  out  1  last alpha of the current word
- alpha_ready_i  in  1  downstream accept
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset is synchronous on rst_n (active-low), clock clk. All outputs reset to 0 and the FSM returns to IDLE. Asserting reset mid-operation drops the word in flight; it is not re-popped.
- Word format: score k is signed two's complement at bits [k*DATA_WIDTH +: DATA_WIDTH]. The count n is at [SOFTMAX_WIDTH-1 -: NUM_NODE_WIDTH]. If n > NUM_OF_NODES, n is clamped to NUM_OF_NODES.
- FSM: IDLE -> MAX -> EXP -> DIV -> OUT -> (DIV | IDLE).
- IDLE:
  - When coef_empty_i == 0, pulse coef_rd_valid_o for 1 cycle and capture coef_data_i and n in that same cycle.
  - If n == 0, stay in IDLE and produce no output. Otherwise go to MAX with i = 0.
- MAX: one score per cycle for n cycles; m = max over x_0..x_{n-1} (signed compare).
- EXP: one score per cycle for n cycles.
  - d = m - x_i, computed unsigned at DATA_WIDTH+1 bits.
  - e_i = (d >= EXP_W) ? 0 : (2^(EXP_W-1) >> d); store e_i.
  - S += e_i, with S of width EXP_W+NUM_NODE_WIDTH, cleared on capture.
  - S >= 2^(EXP_W-1) always holds, so the divisor is never 0.
- DIV: restoring division q = floor(e_i*2^FRAC_W / S) in ALPHA_W cycles.
  - First cycle: r = e_i, q_FRAC_W = (r >= S), subtract S if set.
  - Each following cycle: r <<= 1, compare, subtract; one quotient bit per cycle, MSB first.
  - Because e_i <= S, q <= 2^FRAC_W.
- OUT:
  - alpha_o = q, alpha_idx_o = i, alpha_valid_o = 1, alpha_last_o = (i == n-1).
  - Outputs are held stable while alpha_ready_i == 0.
  - On the handshake: if last, go to IDLE; else i++ and go to DIV.
  - A new pop is allowed in the cycle after the last handshake, never earlier.
- Latency from pop to first alpha_valid_o: 1 + 2n + ALPHA_W cycles. After that, each further alpha needs ALPHA_W + 1 cycles, assuming ready is always high.
- coef_empty_i is ignored outside IDLE. coef_rd_valid_o is never asserted while coef_empty_i == 1.

Optional Feature:
- Macro SOFTMAX_ROUND_EN.
- When defined: DIV takes one extra cycle. q += (2r >= S) using the final remainder, giving round-to-nearest. No overflow is possible, since q == 2^FRAC_W implies r == 0.
- When undefined: the quotient is truncated, ALPHA_W cycles per element.

Test Plan:
- All tests use default parameters.
- Equal scores: n=2, scores [4,4]:
  - e = 32768, 32768; S = 65536.
  - Response: alpha 128 then 128 (idx 0, idx 1), last on idx 1, exactly one pop.
- Three scores: n=3, scores [5,4,3]:
  - e = 32768, 16384, 8192; S = 57344.
  - Response: alpha 146, 73, 36 (37 for idx 2 with SOFTMAX_ROUND_EN).
- Single neighbour: n=1, score [-7] -> alpha 256 with last = 1. Then n=0 word -> popped, no alpha_valid_o, FSM back in IDLE.
- Large spread: n=2, scores [100,-100] -> d = 200 >= 16 gives e_1 = 0; alpha 256, 0.
  - Also n=200: count clamped to 168, exactly 168 alphas emitted.
- Backpressure and empty:
  - alpha_ready_i low for 10 cycles in OUT -> alpha_o, alpha_idx_o and alpha_valid_o stable; no pop.
  - Two words queued -> second pop occurs only after the last handshake of the first.
  - coef_empty_i high -> coef_rd_valid_o stays 0.
- Reset mid-DIV: rst_n low for 1 cycle -> all outputs 0, IDLE. Next FIFO word is processed cleanly from idx 0.

Source files
------------

// File: rtl/softmax_unit.sv
// Base-2, max-subtracted integer softmax over one FIFO word of neighbour scores.
// Optional SOFTMAX_ROUND_EN: round alpha to nearest at the cost of one extra divide cycle.
module softmax_unit #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_OF_NODES   = 168,
  parameter int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
  parameter int SOFTMAX_WIDTH  = NUM_OF_NODES*DATA_WIDTH+NUM_NODE_WIDTH,
  parameter int EXP_W          = 16,
  parameter int FRAC_W         = 8,
  parameter int ALPHA_W        = FRAC_W+1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SOFTMAX_WIDTH-1:0]  coef_data_i,
  input  logic                      coef_empty_i,
  output logic                      coef_rd_valid_o,
  output logic [ALPHA_W-1:0]        alpha_o,
  output logic [NUM_NODE_WIDTH-1:0] alpha_idx_o,
  output logic                      alpha_valid_o,
  output logic                      alpha_last_o,
  input  logic                      alpha_ready_i,
  output logic                      busy_o
);

  localparam int S_W    = EXP_W + NUM_NODE_WIDTH;
  localparam int R_W    = S_W + 1;
  localparam int STEP_W = $clog2(ALPHA_W + 2);
  localparam logic [EXP_W-1:0] E_ONE = {1'b1, {(EXP_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAX, EXP, DIV, OUT} state_t;

  state_t                    state_q, state_d;
  logic [SOFTMAX_WIDTH-1:0]  word_q, word_d;
  logic [NUM_NODE_WIDTH-1:0] n_q, n_d, i_q, i_d;
  logic signed [DATA_WIDTH-1:0] m_q, m_d;
  logic [S_W-1:0]            s_q, s_d, r_q, r_d;
  logic [ALPHA_W-1:0]        q_q, q_d;
  logic [STEP_W-1:0]         step_q, step_d;

  logic [EXP_W-1:0]          e_mem [NUM_OF_NODES];
  logic [EXP_W-1:0]          e_rd_q;
  logic                      e_we;

  logic [NUM_NODE_WIDTH-1:0] n_raw, n_clamp;
  logic signed [DATA_WIDTH-1:0] x_cur;
  logic [DATA_WIDTH:0]       diff;
  logic [EXP_W-1:0]          e_new;
  logic [R_W-1:0]            r_cur;
  logic                      ge, is_last, pop;
  logic [ALPHA_W-1:0]        q_shift;
`ifdef SOFTMAX_ROUND_EN
  logic                      round_up;
  assign round_up = {r_q, 1'b0} >= {1'b0, s_q};
`endif

  assign n_raw   = coef_data_i[SOFTMAX_WIDTH-1 -: NUM_NODE_WIDTH];
  assign n_clamp = (n_raw > NUM_NODE_WIDTH'(NUM_OF_NODES)) ? NUM_NODE_WIDTH'(NUM_OF_NODES) : n_raw;
  assign x_cur   = word_q[i_q*DATA_WIDTH +: DATA_WIDTH];
  // m >= x_i always, so the one-bit-wider difference is a plain magnitude
  assign diff    = {m_q[DATA_WIDTH-1], m_q} - {x_cur[DATA_WIDTH-1], x_cur};
  assign e_new   = (diff >= (DATA_WIDTH+1)'(EXP_W)) ? '0 : (E_ONE >> diff);
  assign is_last = (i_q == n_q - 1'b1);
  assign r_cur   = (step_q == '0) ? R_W'(e_rd_q) : {r_q, 1'b0};
  assign ge      = (r_cur >= {1'b0, s_q});
  assign q_shift = (step_q == '0) ? {{(ALPHA_W-1){1'b0}}, ge} : {q_q[ALPHA_W-2:0], ge};

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    n_d     = n_q;
    i_d     = i_q;
    m_d     = m_q;
    s_d     = s_q;
    r_d     = r_q;
    q_d     = q_q;
    step_d  = step_q;
    e_we    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && !coef_empty_i) begin
          pop     = 1'b1;
          word_d  = coef_data_i;
          n_d     = n_clamp;
          i_d     = '0;
          s_d     = '0;
          state_d = (n_clamp == '0) ? IDLE : MAX;
        end
      end
      MAX: begin
        if (i_q == '0 || x_cur > m_q) m_d = x_cur;
        if (is_last) begin
          i_d     = '0;
          state_d = EXP;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      EXP: begin
        e_we = 1'b1;
        s_d  = s_q + S_W'(e_new);
        if (is_last) begin
          i_d     = '0;
          step_d  = '0;
          state_d = DIV;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      DIV: begin
        step_d = step_q + 1'b1;
`ifdef SOFTMAX_ROUND_EN
        if (step_q == STEP_W'(ALPHA_W)) begin
          q_d     = q_q + ALPHA_W'(round_up);
          state_d = OUT;
        end else begin
          r_d = S_W'(ge ? r_cur - {1'b0, s_q} : r_cur);
          q_d = q_shift;
        end
`else
        r_d = S_W'(ge ? r_cur - {1'b0, s_q} : r_cur);
        q_d = q_shift;
        if (step_q == STEP_W'(ALPHA_W-1)) state_d = OUT;
`endif
      end
      OUT: begin
        if (alpha_ready_i) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            i_d     = i_q + 1'b1;
            step_d  = '0;
            state_d = DIV;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      q_q     <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      q_q     <= q_d;
      step_q  <= step_d;
    end
    word_q <= word_d;
    m_q    <= m_d;
    s_q    <= s_d;
    r_q    <= r_d;
  end

  // Read address is the next index so e_i is ready on the first divide cycle;
  // the bypass covers n == 1, where the only write and that read coincide.
  always_ff @(posedge clk) begin
    if (e_we) e_mem[i_q] <= e_new;
    e_rd_q <= (e_we && i_q == i_d) ? e_new : e_mem[i_d];
  end

  assign coef_rd_valid_o = pop;
  assign alpha_o         = q_q;
  assign alpha_idx_o     = i_q;
  assign alpha_valid_o   = (state_q == OUT);
  assign alpha_last_o    = (state_q == OUT) && is_last;
  assign busy_o          = (state_q != IDLE);

endmodule
